pe_array_ctrl: RTL

Sequencer that drives the control side of the PE array: it owns the mux-select, compute, and register-file enable buses the array consumes, and reacts to the array's `pe_resp`. One `start` runs one complete pass: clear, weight load, activation load, K-tap compute, accumulate, row-by-row drain. It sits between the top-level layer scheduler (start/done) and the PE array, with valid/ready handshakes toward the weight, activation and output buffers.

---
 rtl/pe_array_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_ctrl.sv
// Control sequencer for the PE array. One start runs a full pass:
// clear, weight load, activation load, K-tap compute, accumulate, row drain.
module pe_array_ctrl #(
  parameter int X_DIM      = 15,
  parameter int Y_DIM      = 15,
  parameter int DATA_WIDTH = 8,
  localparam int RW        = (Y_DIM > 1) ? $clog2(Y_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [3:0]            filt_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  wt_valid_i,
  output logic                  wt_ready_o,
  input  logic                  actn_valid_i,
  output logic                  actn_ready_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [RW-1:0]         out_row_o,
  output logic [3:0]            pe_mux_ctrl_o,
  output logic [4:0]            pe_compute_ctrl_o,
  input  logic [1:0]            pe_resp_i,
  output logic [1:0][Y_DIM-1:0] pe_if_rf_ctrl_o,
  output logic [1:0]            pe_wt_rf_ctrl_o,
  output logic [1:0][Y_DIM-1:0] pe_of_rf_ctrl_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_LOAD_WT = 3'd2,
    S_LOAD_IF = 3'd3,
    S_COMPUTE = 3'd4,
    S_ACC     = 3'd5,
    S_DRAIN   = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  state_e        state_q;
  logic [3:0]    k_q;
  logic [3:0]    klen_q;
  logic [RW-1:0] r_q;
  logic          err_q;

  logic stall_s;
  logic abort_s;
  logic k_last_s;
  logic r_last_s;

  assign stall_s  = pe_resp_i[0];
  assign abort_s  = pe_resp_i[1] && (state_q != S_IDLE);
  assign k_last_s = (k_q == (klen_q - 4'd1));
  assign r_last_s = (r_q == RW'(Y_DIM - 1));
  assign err_o    = err_q;

  // Pass sequencing: state, tap/beat counter, row counter, latched K, error pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      klen_q  <= 4'd0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (abort_s) begin
        state_q <= S_IDLE;
        k_q     <= 4'd0;
        r_q     <= '0;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              if (filt_len_i != 4'd0) begin
                klen_q  <= filt_len_i;
                k_q     <= 4'd0;
                r_q     <= '0;
                state_q <= S_CLR;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_CLR: state_q <= S_LOAD_WT;
          S_LOAD_WT: begin
            if (wt_valid_i) begin
              if (k_last_s) begin
                k_q     <= 4'd0;
                state_q <= S_LOAD_IF;
              end else begin
                k_q <= k_q + 4'd1;
              end
            end
          end
          S_LOAD_IF: begin
            if (actn_valid_i) begin
              if (k_last_s) begin
                k_q <= 4'd0;
                if (r_last_s) begin
                  r_q     <= '0;
                  state_q <= S_COMPUTE;
                end else begin
                  r_q <= r_q + RW'(1);
                end
              end else begin
                k_q <= k_q + 4'd1;
              end
            end
          end
          // A stalled tap holds k so the same tap is reissued afterwards.
          S_COMPUTE: begin
            if (!stall_s) begin
              if (k_last_s) begin
                k_q     <= 4'd0;
                state_q <= S_ACC;
              end else begin
                k_q <= k_q + 4'd1;
              end
            end
          end
          S_ACC: begin
            r_q     <= '0;
            state_q <= S_DRAIN;
          end
          S_DRAIN: begin
            if (out_ready_i) begin
              if (r_last_s) begin
                r_q     <= '0;
                state_q <= S_DONE;
              end else begin
                r_q <= r_q + RW'(1);
              end
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            r_q     <= '0;
          end
        endcase
      end
    end
  end

  // Output decode from registered state; RF write enables follow the valids directly.
  always_comb begin
    busy_o            = (state_q != S_IDLE);
    done_o            = (state_q == S_DONE);
    wt_ready_o        = 1'b0;
    actn_ready_o      = 1'b0;
    out_valid_o       = 1'b0;
    out_row_o         = '0;
    pe_mux_ctrl_o     = 4'd0;
    pe_compute_ctrl_o = 5'd0;
    pe_if_rf_ctrl_o   = '0;
    pe_wt_rf_ctrl_o   = 2'd0;
    pe_of_rf_ctrl_o   = '0;
    case (state_q)
      S_CLR: pe_compute_ctrl_o[2] = 1'b1;
      S_LOAD_WT: begin
        wt_ready_o         = 1'b1;
        pe_mux_ctrl_o[1]   = 1'b1;
        pe_wt_rf_ctrl_o[0] = wt_valid_i;
      end
      S_LOAD_IF: begin
        actn_ready_o     = 1'b1;
        pe_mux_ctrl_o[0] = 1'b1;
        for (int i = 0; i < Y_DIM; i++) begin
          pe_if_rf_ctrl_o[0][i] = actn_valid_i && (r_q == RW'(i));
        end
      end
      S_COMPUTE: begin
        if (!stall_s) begin
          pe_if_rf_ctrl_o[1]   = '1;
          pe_wt_rf_ctrl_o[1]   = 1'b1;
          pe_compute_ctrl_o[0] = 1'b1;
          pe_compute_ctrl_o[1] = 1'b1;
          if (k_q == 4'd0) begin
            pe_compute_ctrl_o[3] = 1'b1;
          end else begin
            pe_mux_ctrl_o[2] = 1'b1;
          end
        end else begin
          pe_compute_ctrl_o = 5'd0;
        end
      end
      S_ACC: begin
        pe_compute_ctrl_o[4] = 1'b1;
        pe_of_rf_ctrl_o[0]   = '1;
      end
      S_DRAIN: begin
        pe_mux_ctrl_o[3] = 1'b1;
        out_valid_o      = 1'b1;
        out_row_o        = r_q;
        for (int i = 0; i < Y_DIM; i++) begin
          pe_of_rf_ctrl_o[1][i] = (r_q == RW'(i));
        end
      end
      default: begin
        wt_ready_o = 1'b0;
      end
    endcase
  end

endmodule
